// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port synchronous data RAM between the instruction-fetch
//   port and the load/store port of the multi-cycle core. The arbiter serves
//   one access at a time and steps it through IDLE -> ACCESS -> WAIT -> RESP.
//   When both ports request in the same IDLE cycle, the port that was not
//   served last wins. A request that is misaligned, has an illegal size, or is
//   out of range goes straight from IDLE to RESP and never touches the RAM.
//
// Ports
//   clk, reset        rising-edge clock; synchronous active-low reset
//   if_req/if_addr    fetch request and byte address (held until if_ack)
//   if_rdata          fetched word, valid with if_ack and held afterwards
//   if_ack/if_err     one-cycle completion pulse; error flag alongside it
//   if_busy           if_req && !if_ack
//   d_req, d_we, d_size, d_unsigned, d_addr, d_wdata
//                     load/store request (held until d_ack); right-aligned
//                     store data; size 00 byte, 01 half, 10 word, 11 illegal
//   d_rdata           extended load data, valid with d_ack and held afterwards
//   d_ack/d_err       one-cycle completion pulse; error flag alongside it
//   d_busy            d_req && !d_ack
//   ram_en, ram_we    RAM strobe (one cycle per access); byte write enables
//   ram_addr          RAM word address
//   ram_wdata         store data replicated across all byte lanes
//   ram_rdata         RAM read data, valid WAIT_STATES+1 cycles after ram_en

module mem_arbiter #(
  parameter int RAM_AW      = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ack,
  output logic              if_err,
  output logic              if_busy,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic              d_unsigned,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_ack,
  output logic              d_err,
  output logic              d_busy,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;
  typedef enum logic {PORT_FETCH, PORT_DATA} port_t;

  // WAIT is left when the counter reaches zero, so it is loaded with N-1.
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t state, state_nx;
  // The last granted port doubles as the port currently being served.
  port_t  last_grant;

  // Latched request attributes
  logic [1:0]  lane_q;
  logic [1:0]  size_q;
  logic        we_q;
  logic        uns_q;
  logic        err_q;
  logic [3:0]  wait_cnt;

  // Held response data and registered RAM strobes
  logic [31:0]       if_rdata_q;
  logic [31:0]       d_rdata_q;
  logic              ram_en_q;
  logic [3:0]        ram_we_q;
  logic [RAM_AW-1:0] ram_addr_q;
  logic [31:0]       ram_wdata_q;

  // ---------------------------------------------------------------------
  // Request selection in IDLE. A fetch is treated as an aligned word load,
  // so one set of alignment/range checks covers both ports.
  // ---------------------------------------------------------------------
  logic        any_req;
  logic        accept;
  port_t       grant_nx;
  logic [31:0] sel_addr;
  logic [1:0]  sel_size;
  logic        sel_we;
  logic        range_err;
  logic        align_err;
  logic        req_err;
  logic [3:0]  sel_be;
  logic [31:0] sel_wdata;

  assign any_req  = if_req | d_req;
  assign accept   = (state == S_IDLE) && any_req;
  assign grant_nx = (d_req && (!if_req || last_grant == PORT_FETCH)) ? PORT_DATA : PORT_FETCH;
  assign sel_addr = (grant_nx == PORT_DATA) ? d_addr : if_addr;
  assign sel_size = (grant_nx == PORT_DATA) ? d_size : 2'b10;
  assign sel_we   = (grant_nx == PORT_DATA) && d_we;

  assign range_err = (sel_addr >> (RAM_AW + 2)) != 32'd0;
  assign req_err   = range_err | align_err;

  // NOTE: every variable written in an always_comb gets a default before any
  // branch, so no path can leave it unassigned and infer a latch.
  always_comb begin
    align_err = 1'b0;
    sel_be    = 4'b1111;
    sel_wdata = d_wdata;
    case (sel_size)
      2'b00: begin
        sel_be    = 4'b0001 << sel_addr[1:0];
        sel_wdata = {4{d_wdata[7:0]}};
      end
      2'b01: begin
        align_err = sel_addr[0];
        sel_be    = sel_addr[1] ? 4'b1100 : 4'b0011;
        sel_wdata = {2{d_wdata[15:0]}};
      end
      2'b10:   align_err = |sel_addr[1:0];
      default: align_err = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (any_req) state_nx = req_err ? S_RESP : S_ACCESS;
      S_ACCESS: state_nx = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
      S_WAIT:   if (wait_cnt == 4'd0) state_nx = S_RESP;
      S_RESP:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Control state and everything visible after reset
  // ---------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples its inputs from before the edge, independent of block order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      last_grant <= PORT_FETCH;
      ram_en_q   <= 1'b0;
      ram_we_q   <= 4'b0000;
      if_rdata_q <= 32'd0;
      d_rdata_q  <= 32'd0;
    end else begin
      state <= state_nx;
      if (accept) last_grant <= grant_nx;
      // The strobe is high for exactly the ACCESS cycle.
      ram_en_q   <= accept && !req_err;
      ram_we_q   <= (accept && !req_err && sel_we) ? sel_be : 4'b0000;
      if_rdata_q <= if_rdata;
      d_rdata_q  <= d_rdata;
    end
  end

  // NOTE: the latched request fields are only read after an accept has loaded
  // them, so they carry no reset and stay plain enable flops.
  always_ff @(posedge clk) begin
    if (accept) begin
      lane_q      <= sel_addr[1:0];
      size_q      <= sel_size;
      we_q        <= sel_we;
      uns_q       <= d_unsigned;
      err_q       <= req_err;
      ram_addr_q  <= sel_addr[RAM_AW+1:2];
      ram_wdata_q <= sel_wdata;
    end
    if (state == S_ACCESS)    wait_cnt <= WAIT_LOAD;
    else if (state == S_WAIT) wait_cnt <= wait_cnt - 4'd1;
  end

  // ---------------------------------------------------------------------
  // Load lane extraction and extension
  // ---------------------------------------------------------------------
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_val;

  always_comb begin
    case (lane_q)
      2'd0:    byte_v = ram_rdata[7:0];
      2'd1:    byte_v = ram_rdata[15:8];
      2'd2:    byte_v = ram_rdata[23:16];
      default: byte_v = ram_rdata[31:24];
    endcase
    half_v = lane_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (size_q)
      2'b00:   load_val = {{24{byte_v[7] & ~uns_q}}, byte_v};
      2'b01:   load_val = {{16{half_v[15] & ~uns_q}}, half_v};
      default: load_val = ram_rdata;
    endcase
  end

  // ---------------------------------------------------------------------
  // Outputs. RAM data is passed through during RESP so it is visible in the
  // ack cycle, and the held copy takes over afterwards.
  // ---------------------------------------------------------------------
  logic resp_ok;
  assign resp_ok = (state == S_RESP) && !err_q;

  assign if_ack   = (state == S_RESP) && (last_grant == PORT_FETCH);
  assign d_ack    = (state == S_RESP) && (last_grant == PORT_DATA);
  assign if_err   = if_ack && err_q;
  assign d_err    = d_ack && err_q;
  assign if_busy  = if_req && !if_ack;
  assign d_busy   = d_req && !d_ack;
  assign if_rdata = (resp_ok && last_grant == PORT_FETCH) ? ram_rdata : if_rdata_q;
  assign d_rdata  = (resp_ok && last_grant == PORT_DATA && !we_q) ? load_val : d_rdata_q;

  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter. Instance u_dut0 (WAIT_STATES=0) runs
//   directed and randomized traffic on both ports against a reference memory
//   model; expected responses are queued per port when a request is issued
//   and a monitor compares them whenever an ack appears. Instance u_dut3
//   (WAIT_STATES=3) covers wait-state latency and reset in the middle of an
//   access.

module tb_mem_arbiter;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {K_LOAD, K_STORE, K_ERR} kind_t;
  typedef struct packed {
    kind_t       kind;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------
  // DUT0 (no wait states)
  // ---------------------------------------------------------------------
  logic          reset0;
  logic          if_req0, if_ack0, if_err0, if_busy0;
  logic [31:0]   if_addr0, if_rdata0;
  logic          d_req0, d_we0, d_unsigned0, d_ack0, d_err0, d_busy0;
  logic [1:0]    d_size0;
  logic [31:0]   d_addr0, d_wdata0, d_rdata0;
  logic          ram_en0;
  logic [3:0]    ram_we0;
  logic [AW-1:0] ram_addr0;
  logic [31:0]   ram_wdata0, ram_rdata0;

  mem_arbiter #(.RAM_AW(AW), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset0),
    .if_req(if_req0), .if_addr(if_addr0), .if_rdata(if_rdata0),
    .if_ack(if_ack0), .if_err(if_err0), .if_busy(if_busy0),
    .d_req(d_req0), .d_we(d_we0), .d_size(d_size0), .d_unsigned(d_unsigned0),
    .d_addr(d_addr0), .d_wdata(d_wdata0), .d_rdata(d_rdata0),
    .d_ack(d_ack0), .d_err(d_err0), .d_busy(d_busy0),
    .ram_en(ram_en0), .ram_we(ram_we0), .ram_addr(ram_addr0),
    .ram_wdata(ram_wdata0), .ram_rdata(ram_rdata0)
  );

  // RAM for DUT0: synchronous, data valid the cycle after ram_en.
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr;
  logic [31:0]   pl_data;
  logic [31:0]   ram0 [DEPTH];

  always @(posedge clk) begin
    if (pl_en) ram0[pl_addr] <= pl_data;
    else if (ram_en0) begin
      for (int b = 0; b < 4; b++)
        if (ram_we0[b]) ram0[ram_addr0][8*b +: 8] <= ram_wdata0[8*b +: 8];
      ram_rdata0 <= ram0[ram_addr0];
    end
  end

  // ---------------------------------------------------------------------
  // DUT3 (three wait states); RAM content is a fixed pattern of the address
  // and read data only appears 4 cycles after the strobe.
  // ---------------------------------------------------------------------
  logic          reset3;
  logic          if_req3, if_ack3, if_err3, if_busy3;
  logic [31:0]   if_addr3, if_rdata3;
  logic          d_req3, d_we3, d_unsigned3, d_ack3, d_err3, d_busy3;
  logic [1:0]    d_size3;
  logic [31:0]   d_addr3, d_wdata3, d_rdata3;
  logic          ram_en3;
  logic [3:0]    ram_we3;
  logic [AW-1:0] ram_addr3;
  logic [31:0]   ram_wdata3, ram_rdata3;
  logic [31:0]   pipe3 [4];

  mem_arbiter #(.RAM_AW(AW), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .reset(reset3),
    .if_req(if_req3), .if_addr(if_addr3), .if_rdata(if_rdata3),
    .if_ack(if_ack3), .if_err(if_err3), .if_busy(if_busy3),
    .d_req(d_req3), .d_we(d_we3), .d_size(d_size3), .d_unsigned(d_unsigned3),
    .d_addr(d_addr3), .d_wdata(d_wdata3), .d_rdata(d_rdata3),
    .d_ack(d_ack3), .d_err(d_err3), .d_busy(d_busy3),
    .ram_en(ram_en3), .ram_we(ram_we3), .ram_addr(ram_addr3),
    .ram_wdata(ram_wdata3), .ram_rdata(ram_rdata3)
  );

  function automatic logic [31:0] pat3(input logic [AW-1:0] a);
    return {6'b0, a, ~a, 6'h2A};
  endfunction

  always @(posedge clk) begin
    pipe3[0] <= ram_en3 ? pat3(ram_addr3) : 32'hDEAD_0000;
    for (int i = 1; i < 4; i++) pipe3[i] <= pipe3[i-1];
  end
  assign ram_rdata3 = pipe3[3];

  // ---------------------------------------------------------------------
  // Reference model for DUT0
  // ---------------------------------------------------------------------
  logic [31:0] ref_mem [DEPTH];
  exp_t        if_q[$];
  exp_t        d_q[$];

  function automatic logic data_bad(input logic [1:0] size, input logic [31:0] addr);
    if (addr >= 32'(4 * DEPTH)) return 1'b1;
    if (size == 2'd3) return 1'b1;
    if (size == 2'd1) return addr[0];
    if (size == 2'd2) return addr[1:0] != 2'd0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] size,
                                           input logic uns, input logic [31:0] addr);
    logic [31:0] v;
    v = word >> (8 * int'(addr[1:0]));
    if (size == 2'd0) begin
      v = v & 32'hFF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      v = v & 32'hFFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // Data-port request: predict the response, queue it, drive until ack.
  task automatic data_op(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, output int lat);
    exp_t e;
    logic got;
    int   nb;
    int   w;
    e.data = 32'd0;
    if (data_bad(size, addr)) e.kind = K_ERR;
    else if (we) begin
      e.kind = K_STORE;
      nb = 1 << size;
      w  = int'(addr[AW+1:2]);
      for (int b = 0; b < nb; b++)
        ref_mem[w][8*(int'(addr[1:0]) + b) +: 8] = wdata[8*b +: 8];
    end else begin
      e.kind = K_LOAD;
      e.data = load_ext(ref_mem[addr[AW+1:2]], size, uns, addr);
    end
    d_q.push_back(e);
    d_we0 = we; d_size0 = size; d_unsigned0 = uns; d_addr0 = addr; d_wdata0 = wdata;
    d_req0 = 1'b1;
    got = 1'b0;
    lat = 0;
    while (!got && lat < 40) begin
      @(negedge clk);
      if (d_ack0) got = 1'b1;
      else lat++;
    end
    check("d_ack_seen", got, 1'b1);
    @(posedge clk); #1;
    d_req0 = 1'b0;
  endtask

  task automatic fetch_op(input logic [31:0] addr, output int lat);
    exp_t e;
    logic got;
    if (addr >= 32'(4 * DEPTH) || addr[1:0] != 2'd0) begin
      e.kind = K_ERR;
      e.data = 32'd0;
    end else begin
      e.kind = K_LOAD;
      e.data = ref_mem[addr[AW+1:2]];
    end
    if_q.push_back(e);
    if_addr0 = addr;
    if_req0  = 1'b1;
    got = 1'b0;
    lat = 0;
    while (!got && lat < 40) begin
      @(negedge clk);
      if (if_ack0) got = 1'b1;
      else lat++;
    end
    check("if_ack_seen", got, 1'b1);
    @(posedge clk); #1;
    if_req0 = 1'b0;
  endtask

  // ---------------------------------------------------------------------
  // Monitor for DUT0
  // ---------------------------------------------------------------------
  logic [31:0] last_if, last_d;
  int          en_cnt;
  logic [3:0]  strobe_we;
  logic [31:0] strobe_wdata, strobe_addr;
  int          strobe_cyc, ack_cyc;
  int          ack_order[$];

  always @(negedge clk) begin
    exp_t e;
    if (!reset0) begin
      last_if = 32'd0;
      last_d  = 32'd0;
      en_cnt  = 0;
    end else begin
      check("if_busy", if_busy0, if_req0 && !if_ack0);
      check("d_busy", d_busy0, d_req0 && !d_ack0);
      check("single_ack", if_ack0 && d_ack0, 1'b0);
      if (ram_en0) begin
        en_cnt++;
        strobe_we    = ram_we0;
        strobe_wdata = ram_wdata0;
        strobe_addr  = 32'(ram_addr0);
        strobe_cyc   = cyc;
      end
      if (if_ack0) begin
        ack_order.push_back(0);
        ack_cyc = cyc;
        if (if_q.size() == 0) check("if_ack_expected", 1'b0, 1'b1);
        else begin
          e = if_q.pop_front();
          check("if_err", if_err0, e.kind == K_ERR);
          check("if_strobes", en_cnt, (e.kind == K_ERR) ? 0 : 1);
          if (e.kind == K_ERR) check("if_rdata_held", if_rdata0, last_if);
          else begin
            check("if_rdata", if_rdata0, e.data);
            last_if = e.data;
          end
        end
        en_cnt = 0;
      end
      if (d_ack0) begin
        ack_order.push_back(1);
        ack_cyc = cyc;
        if (d_q.size() == 0) check("d_ack_expected", 1'b0, 1'b1);
        else begin
          e = d_q.pop_front();
          check("d_err", d_err0, e.kind == K_ERR);
          check("d_strobes", en_cnt, (e.kind == K_ERR) ? 0 : 1);
          if (e.kind == K_ERR) check("d_rdata_held", d_rdata0, last_d);
          else if (e.kind == K_LOAD) begin
            check("d_rdata", d_rdata0, e.data);
            last_d = e.data;
          end else last_d = d_rdata0;
        end
        en_cnt = 0;
      end
    end
  end

  task automatic reset_dut0();
    reset0 = 1'b0;
    if_req0 = 1'b0; d_req0 = 1'b0;
    if_q.delete(); d_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_if_ack", if_ack0, 1'b0);
    check("rst_d_ack", d_ack0, 1'b0);
    check("rst_errs", {if_err0, d_err0}, 2'b00);
    check("rst_ram_en", ram_en0, 1'b0);
    check("rst_ram_we", ram_we0, 4'b0000);
    check("rst_if_rdata", if_rdata0, 32'd0);
    check("rst_d_rdata", d_rdata0, 32'd0);
    @(posedge clk); #1;
    reset0 = 1'b1;
  endtask

  // ---------------------------------------------------------------------
  // DUT0 stimulus
  // ---------------------------------------------------------------------
  logic done3 = 1'b0;
  int   lat_a, lat_b;

  initial begin
    reset0 = 1'b0;
    if_req0 = 1'b0; if_addr0 = 32'd0;
    d_req0 = 1'b0; d_we0 = 1'b0; d_size0 = 2'd0; d_unsigned0 = 1'b0;
    d_addr0 = 32'd0; d_wdata0 = 32'd0;

    // Preload RAM and model with the same contents.
    for (int i = 0; i < DEPTH; i++) begin
      pl_addr = AW'(i);
      pl_data = (i == 5) ? 32'h0050_0093 : $urandom;
      ref_mem[i] = pl_data;
      pl_en = 1'b1;
      @(posedge clk); #1;
    end
    pl_en = 1'b0;

    reset_dut0();

    // Plain fetch: strobe in cycle 1, ack in cycle 2.
    fetch_op(32'h14, lat_a);
    check("fetch_lat", lat_a, 2);
    check("fetch_ram_addr", strobe_addr, 32'd5);
    check("fetch_strobe_to_ack", ack_cyc - strobe_cyc, 1);
    check("fetch_word", if_rdata0, 32'h0050_0093);

    // Byte store then signed and unsigned byte load.
    data_op(1'b1, 2'b00, 1'b0, 32'h103, 32'h0000_00F0, lat_a);
    check("sb_lat", lat_a, 2);
    check("sb_ram_we", strobe_we, 4'b1000);
    check("sb_ram_wdata", strobe_wdata, 32'hF0F0_F0F0);
    check("sb_ram_addr", strobe_addr, 32'h40);
    data_op(1'b0, 2'b00, 1'b0, 32'h103, 32'd0, lat_a);
    check("lb_value", d_rdata0, 32'hFFFF_FFF0);
    data_op(1'b0, 2'b00, 1'b1, 32'h103, 32'd0, lat_a);
    check("lbu_value", d_rdata0, 32'h0000_00F0);

    // Half store / signed half load round trip.
    data_op(1'b1, 2'b01, 1'b0, 32'h302, 32'h1234_8765, lat_a);
    check("sh_ram_we", strobe_we, 4'b1100);
    check("sh_ram_wdata", strobe_wdata, 32'h8765_8765);
    data_op(1'b0, 2'b01, 1'b0, 32'h302, 32'd0, lat_a);
    check("lh_value", d_rdata0, 32'hFFFF_8765);

    // Error paths: ack in cycle 1, no strobe, data held.
    data_op(1'b0, 2'b01, 1'b0, 32'h201, 32'd0, lat_a);
    check("half_misalign_lat", lat_a, 1);
    check("half_misalign_rdata", d_rdata0, 32'hFFFF_8765);
    fetch_op(32'h0000_1000, lat_a);
    check("fetch_range_lat", lat_a, 1);
    data_op(1'b1, 2'b10, 1'b0, 32'h202, 32'hFFFF_FFFF, lat_a);
    data_op(1'b0, 2'b11, 1'b0, 32'h200, 32'd0, lat_a);
    data_op(1'b1, 2'b00, 1'b0, 32'h0001_0000, 32'h55, lat_a);

    // Tie right after reset: data first, fetch three cycles later.
    reset_dut0();
    fork
      data_op(1'b0, 2'b10, 1'b0, 32'h100, 32'd0, lat_a);
      fetch_op(32'h20, lat_b);
    join
    check("tie_data_lat", lat_a, 2);
    check("tie_fetch_lat", lat_b, 5);

    // Both ports re-requesting immediately: grants alternate, data first.
    ack_order.delete();
    fork
      begin
        int lt;
        for (int i = 0; i < 6; i++)
          data_op(1'b0, 2'b10, 1'b0, 32'($urandom_range(0, DEPTH - 1)) << 2, 32'd0, lt);
      end
      begin
        int lt;
        for (int i = 0; i < 6; i++)
          fetch_op(32'($urandom_range(0, 127)) << 2, lt);
      end
    join
    check("alt_count", ack_order.size(), 12);
    for (int i = 0; i < ack_order.size(); i++)
      check("alt_order", ack_order[i], (i % 2 == 0) ? 1 : 0);

    // Randomized concurrent traffic. Stores stay out of the fetch region.
    fork
      begin
        int          lt;
        logic [31:0] a;
        for (int i = 0; i < 150; i++) begin
          a = 32'($urandom_range(0, 127)) << 2;
          if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
          else if ($urandom_range(0, 7) == 0) a = a | 32'h0000_1000;
          fetch_op(a, lt);
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
      end
      begin
        int          lt;
        logic        we, uns;
        logic [1:0]  sz;
        logic [31:0] a;
        for (int i = 0; i < 250; i++) begin
          we  = ($urandom_range(0, 2) == 0);
          uns = 1'($urandom_range(0, 1));
          sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
          a   = 32'($urandom_range(0, 4 * DEPTH - 1));
          if ($urandom_range(0, 9) < 7) begin
            if (sz == 2'd1) a[0] = 1'b0;
            if (sz == 2'd2) a[1:0] = 2'd0;
          end
          if ($urandom_range(0, 11) == 0) a = $urandom | 32'h0000_1000;
          if (we && a < 32'd512) a = a + 32'd512;
          data_op(we, sz, uns, a, $urandom, lt);
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
      end
    join

    check("if_queue_drained", if_q.size(), 0);
    check("d_queue_drained", d_q.size(), 0);

    begin
      int t = 0;
      while (!done3 && t < 2000) begin @(posedge clk); t++; end
      check("dut3_done", done3, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // ---------------------------------------------------------------------
  // DUT3 stimulus: wait-state latency and reset mid-access
  // ---------------------------------------------------------------------
  task automatic load3(input logic [31:0] addr, output int lat, output int ens);
    logic got;
    d_addr3 = addr; d_size3 = 2'b10; d_we3 = 1'b0;
    d_req3 = 1'b1;
    got = 1'b0; lat = 0; ens = 0;
    while (!got && lat < 40) begin
      @(negedge clk);
      if (ram_en3) ens++;
      if (d_ack3) got = 1'b1;
      else lat++;
    end
    check("d3_ack_seen", got, 1'b1);
    @(posedge clk); #1;
    d_req3 = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (ram_en3) ens++;
    end
  endtask

  initial begin
    int lat, ens;
    reset3 = 1'b0;
    if_req3 = 1'b0; if_addr3 = 32'd0;
    d_req3 = 1'b0; d_we3 = 1'b0; d_size3 = 2'd0; d_unsigned3 = 1'b0;
    d_addr3 = 32'd0; d_wdata3 = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("d3_rst_outputs", {d_ack3, if_ack3, ram_en3, ram_we3}, 7'd0);
    @(posedge clk); #1;
    reset3 = 1'b1;

    load3(32'h40, lat, ens);
    check("ws3_lat", lat, 5);
    check("ws3_ram_en_once", ens, 1);
    check("ws3_rdata", d_rdata3, pat3(10'd16));
    check("ws3_err", d_err3, 1'b0);

    // Reset asserted during WAIT abandons the access.
    d_addr3 = 32'h44; d_size3 = 2'b10; d_req3 = 1'b1;
    repeat (3) @(negedge clk);
    reset3 = 1'b0;
    d_req3 = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("rst_mid_no_ack", {d_ack3, if_ack3, d_err3, if_err3}, 4'd0);
      check("rst_mid_ram", {ram_en3, ram_we3}, 5'd0);
      check("rst_mid_rdata", d_rdata3 | if_rdata3, 32'd0);
    end
    @(posedge clk); #1;
    reset3 = 1'b1;

    load3(32'h48, lat, ens);
    check("post_rst_lat", lat, 5);
    check("post_rst_rdata", d_rdata3, pat3(10'd18));
    done3 = 1'b1;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port synchronous data RAM between the instruction-fetch port and the load/store port of the multi-cycle core.
- Arbitrates fetch and data requests and sequences each access through a fixed wait-state count.
- Handles byte-lane steering and byte enables for stores, and byte/half sign or zero extension for loads.
- Flags misaligned and out-of-range accesses without touching the RAM.
- Drives the core FSM's mem_busy through the per-port busy outputs.

Parameters:
- RAM_AW, 10: RAM word-address width. Depth is 2**RAM_AW words.
- WAIT_STATES, 0: extra cycles between ram_en and a valid ram_rdata, range 0..15.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- if_req  in  1  fetch request; held with if_addr until if_ack
- if_addr  in  32  fetch byte address
- if_rdata  out  32  fetched word; valid while if_ack=1, then held
- if_ack  out  1  one-cycle completion pulse
- if_err  out  1  with if_ack: misaligned or out of range
- if_busy  out  1  if_req && !if_ack
- d_req  in  1  data request; held with the other d_* inputs until d_ack
- d_we  in  1  1=store, 0=load
- d_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- d_unsigned  in  1  load zero-extend (LBU/LHU)
- d_addr  in  32  data byte address
- d_wdata  in  32  store data, right-aligned
- d_rdata  out  32  extended load data; valid while d_ack=1, then held
- d_ack  out  1  one-cycle completion pulse
- d_err  out  1  with d_ack: misaligned, illegal size, or out of range
- d_busy  out  1  d_req && !d_ack
- ram_en  out  1  RAM access strobe, one cycle per access
- ram_we  out  4  byte write enables, all 0 for reads
- ram_addr  out  RAM_AW  word address = addr[RAM_AW+1:2]
- ram_wdata  out  32  lane-replicated store data
- ram_rdata  in  32  RAM read data

Behaviour:
- Reset (reset=0 at a clk edge):
  - State returns to IDLE.
  - if_ack, d_ack, if_err, d_err, ram_en, ram_we, if_rdata, d_rdata all go to 0.
  - last_grant is set to FETCH.
  - Reset mid-access abandons the access: no ack is issued, and any write already strobed stands.
- State machine: IDLE -> ACCESS -> WAIT -> RESP -> IDLE. An error path runs IDLE -> RESP directly.
- IDLE:
  - Samples if_req and d_req.
  - If only one is high, that port is granted.
  - If both are high, the port not equal to last_grant wins (round-robin), so data wins the first tie after reset.
  - The granted port's address, size and data are latched, and last_grant is updated.
- Error checks in IDLE, on the latched request:
  - Fetch errors: if_addr[1:0]!=0, or if_addr[31:RAM_AW+2]!=0.
  - Data errors: size 11; half with addr[0]=1; word with addr[1:0]!=0; or out of range.
  - On error the machine goes to RESP with err=1. No ram_en is raised, and rdata is unchanged.
- ACCESS (one cycle):
  - ram_en=1, driven registered.
  - ram_we = byte mask for a store (byte: 1<<addr[1:0]; half: 0011 or 1100 by addr[1]; word: 1111), otherwise 0000.
  - ram_wdata = byte replicated x4, half replicated x2, or the word.
- WAIT: counts WAIT_STATES cycles. It is skipped when WAIT_STATES=0.
- RESP:
  - Captures ram_rdata and extracts the lane selected by addr[1:0].
  - Signed loads sign-extend; d_unsigned=1 zero-extends.
  - Fetch returns the raw word.
  - Pulses the granted port's ack (with err) for exactly one cycle, then goes to IDLE unconditionally.
  - req is not sampled in RESP.
- Latency, from the cycle req is first seen in IDLE (cycle 0):
  - Successful access: ack in cycle 2+WAIT_STATES.
  - Error: ack in cycle 1.
  - Minimum spacing between accepted accesses is 3+WAIT_STATES cycles.
- Handshake:
  - The requester holds req and its signals stable until ack.
  - It may present a new request in the cycle after ack; IDLE accepts it that cycle.
  - A losing requester simply waits; its busy stays 1.
- Request dropped before ack: the access still completes and the ack pulse is still issued; the requester ignores it.
- Only one ack is ever high in a cycle. if_ack and d_ack are never high together.

Test Plan:
- Fetch, WAIT_STATES=0:
  - Stimulus: RAM[5]=0x00500093; if_req with if_addr=0x14.
  - Required: ram_en in cycle 1 with ram_addr=5; if_ack in cycle 2 with if_rdata=0x00500093 and if_err=0.
- Byte store then signed and unsigned load:
  - Store: d_we=1, size=00, addr=0x103, wdata=0x000000F0 -> ram_we=1000, ram_wdata=0xF0F0F0F0.
  - LB from 0x103 -> d_rdata=0xFFFFFFF0.
  - LBU from 0x103 -> d_rdata=0x000000F0.
- Tie arbitration after reset:
  - if_req and d_req both high -> data is acked first.
  - Fetch is acked 3 cycles later with if_busy=1 throughout the wait.
  - With both requests re-asserted immediately, the order alternates.
- Errors:
  - Half load at 0x201 -> d_ack in cycle 1 with d_err=1, no ram_en, d_rdata unchanged.
  - Fetch at 0x00001000 with RAM_AW=10 -> if_err=1.
- WAIT_STATES=3:
  - Word load from 0x40 -> d_ack in cycle 5.
  - ram_en is high exactly once.
- Reset mid-access:
  - Stimulus: reset=0 in the WAIT cycle.
  - Required: no ack; state IDLE; all outputs 0.
  - A request issued after reset is released completes normally.
